ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends single command bytes to the mouse, e.g. 0xF4 (enable data reporting) and 0xFF (reset).
- Sits beside the existing PS/2 mouse receiver and shares the same ps2_clk/ps2_data open-drain pads. The top level builds the tristates from the *_oe outputs.
- Performs the full sequence: inhibit, request-to-send, 11-bit frame clocked by the device, then ACK check.
- Asserts busy so the receiver ignores line activity during the transmission.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles ps2_clk is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk cycles between consecutive device falling edges, or until bus-idle (15 ms).
- FILTER_LEN, 4: cycles a synced PS/2 line must be stable before its filtered value changes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Asynchronous, active-high.
- tx_data  in  8  byte to send
- tx_valid  in  1  request. Accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: byte sent and ACK received
- err  out  1  one-cycle pulse: NACK or timeout
- ps2_clk_in  in  1  raw pad value (asynchronous)
- ps2_data_in  in  1  raw pad value (asynchronous)
- ps2_clk_oe  out  1  1 = drive pad low, 0 = release
- ps2_data_oe  out  1  1 = drive pad low, 0 = release

Behaviour:
- Reset values: state IDLE, tx_ready=1, busy=0, done=0, err=0, both *_oe=0, counters 0. Async rst releases both lines immediately, including mid-frame.
- Line conditioning: both inputs pass through a 2-flop synchronizer and then the FILTER_LEN filter. "fall" is a one-cycle pulse on a filtered ps2_clk 1->0 transition.
- Acceptance: on accept, latch frame = {1 (stop), ~^tx_data (odd parity), tx_data}. Data bits go out LSB first.
- IDLE -> INHIBIT on accept.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe rises in the last inhibit cycle (start bit = 0).
  - Then -> SEND with ps2_clk_oe=0.
- SEND:
  - Bit counter starts at 0.
  - On each fall: ps2_data_oe = ~frame[cnt], then cnt++. The host updates data while the clock is low.
  - The 10th fall outputs the stop bit (release), then -> WAIT_ACK.
- WAIT_ACK: on fall, sample filtered data.
  - 0 -> WAIT_IDLE.
  - 1 -> NACK: err pulse, -> IDLE.
- WAIT_IDLE: when filtered clk=1 and data=1, pulse done and go -> IDLE.
- Timeout:
  - The timeout counter clears on entry to SEND and on every fall.
  - If it reaches TIMEOUT_CYCLES in SEND, WAIT_ACK or WAIT_IDLE: err pulse, both oe=0, -> IDLE.
- done and err are never asserted in the same cycle.
- tx_valid while busy is ignored and is not queued.
- The cycle after done/err, tx_ready=1. A back-to-back request is accepted on that cycle.
- Parity rule, 0xF4 example: five ones gives parity 0.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, restart from INHIBIT with the latched byte, up to 2 retries.
  - err pulses only after the 3rd failure.
  - A retry counter clears on accept.
  - busy stays high throughout the retries.
- Undefined: the first failure pulses err, with no retry logic.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, SEND, WAIT_ACK, WAIT_IDLE)
  - command constants: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA
  - odd-parity function
  - frame length constant 11
- Sub-module ps2_line_cond: synchronizer, FILTER_LEN stability filter and falling-edge detector. Instantiated once per line and reusable by the receiver.

Test Plan:
(Bench uses INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=500, with a device model that clocks at a 60-cycle period.)
- Send 0xF4, model ACKs -> ps2_clk_oe high exactly 20 cycles; device samples 0,0,1,0,1,1,1,1, parity 0, stop 1; done pulses once; err stays 0.
- Send 0xFF -> model sees parity bit 1 and a correct frame; done pulses.
- Model leaves data high at the 11th clock (NACK) -> err pulse; tx_ready=1 the next cycle; both oe=0.
- Model never clocks after request-to-send -> err exactly 500 cycles after SEND entry; lines released.
- rst asserted at bit 4 -> same cycle: both oe=0, busy=0; next byte after rst deassert sends correctly.
- tx_valid pulsed during busy, then a back-to-back request the cycle after done -> first extra ignored; second accepted immediately.
- With PS2_TX_RETRY_EN, model NACKs twice then ACKs -> three inhibit phases, single done, no err.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, command constants and parity helper for the PS/2 host blocks.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, WAIT_ACK, WAIT_IDLE} state_t;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RESP_ACK   = 8'hFA;
  localparam int FRAME_LEN = 11;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_cond.sv
// ps2_line_cond: 2-flop synchronizer, stability filter and falling-edge pulse for one PS/2 line.
module ps2_line_cond #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync_q;
  logic filt_q, filt_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The filtered value only follows the synced line after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d = '0;
    if (sync_q[1] != filt_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
        cnt_d = '0;
      end
    end
    fall_d = filt_q & ~filt_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      filt_q <= filt_d;
      cnt_q <= cnt_d;
      fall_q <= fall_d;
    end
  assign filt = filt_q;
  assign fall = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (inhibit, request-to-send, device-clocked frame, ACK).
// Define PS2_TX_RETRY_EN to retry a failed byte up to twice before reporting err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [9:0] frame_q, frame_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic clk_f, clk_fall, data_f, data_fall_unused, fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_q, retry_d;
`endif
  ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_clk_cond (
    .clk(clk), .rst(rst), .raw(ps2_clk_in), .filt(clk_f), .fall(clk_fall)
  );
  ps2_line_cond #(.FILTER_LEN(FILTER_LEN)) u_data_cond (
    .clk(clk), .rst(rst), .raw(ps2_data_in), .filt(data_f), .fall(data_fall_unused)
  );
  always_comb begin
    state_d = state_q;
    byte_d = byte_q;
    frame_d = frame_q;
    cnt_d = cnt_q;
    inh_d = inh_q;
    tmo_d = (state_q == IDLE || state_q == INHIBIT || clk_fall) ? '0 : tmo_q + 1'b1;
    clk_oe_d = clk_oe_q;
    data_oe_d = data_oe_q;
    done = 1'b0;
    fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = INHIBIT;
        byte_d = tx_data;
        inh_d = '0;
        clk_oe_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
        retry_d = '0;
`endif
      end
      // Start bit is driven in the last inhibit cycle so it is already low when the clock is released.
      INHIBIT: begin
        inh_d = inh_q + 1'b1;
        data_oe_d = data_oe_q | (inh_q == IW'(INHIBIT_CYCLES - 2));
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          state_d = SEND;
          clk_oe_d = 1'b0;
          cnt_d = '0;
          frame_d = {1'b1, odd_parity(byte_q), byte_q};
        end
      end
      SEND: if (clk_fall) begin
        data_oe_d = ~frame_q[0];
        frame_d = {1'b1, frame_q[9:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 4'(FRAME_LEN - 2)) state_d = WAIT_ACK;
      end
      WAIT_ACK: if (clk_fall) begin
        if (data_f) fail = 1'b1;
        else state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_f && data_f) begin
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != INHIBIT && tmo_q == TW'(TIMEOUT_CYCLES) && !done) fail = 1'b1;
    if (fail) begin
      state_d = IDLE;
      clk_oe_d = 1'b0;
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 1'b1;
        state_d = INHIBIT;
        inh_d = '0;
        clk_oe_d = 1'b1;
      end
`endif
    end
    err = fail && state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      byte_q <= '0;
      frame_q <= '0;
      cnt_q <= '0;
      inh_q <= '0;
      tmo_q <= '0;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      frame_q <= frame_d;
      cnt_q <= cnt_d;
      inh_q <= inh_d;
      tmo_q <= tmo_d;
      clk_oe_q <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) retry_q <= '0;
    else retry_q <= retry_d;
`endif
  assign tx_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model and per-cycle rule checker.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 500;
  localparam int HALF = 30;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  int checks = 0, fails = 0, cyc = 0;
  int inh_runs = 0, run_len = 0, send_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0;
  logic prev_acc = 1'b0, prev_end = 1'b0;
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Odd parity from the bit count: the frame's ones including parity must be odd.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ones % 2 == 0, b};
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      prev_acc = 1'b0;
      prev_end = 1'b0;
    end else begin
      check("ready_vs_busy", tx_ready, !busy);
      check("done_err_excl", done & err, 0);
      if (!busy) check("idle_released", {ps2_clk_oe, ps2_data_oe}, 0);
      if (prev_acc) check("busy_after_accept", busy, 1);
      if (prev_end) check("ready_after_end", tx_ready, 1);
      if (ps2_clk_oe) run_len++;
      else if (run_len != 0) begin
        check("inhibit_len", run_len, INH);
        inh_runs++;
        send_cyc = cyc;
        run_len = 0;
      end
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_acc = tx_valid & tx_ready;
      prev_end = done | err;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 2000) begin
      tick(1);
      t++;
    end
    check("ready_before_send", tx_ready, 1);
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask
  task automatic wait_rts(input int min_runs);
    int t = 0;
    while (inh_runs < min_runs && t < 300) begin
      tick(1);
      t++;
    end
    check("rts_seen", inh_runs >= min_runs, 1);
  endtask
  // Device side: clocks 11 bits, samples on rising edges, drives ACK low after the stop bit.
  task automatic dev_frame(input int min_runs, input bit ack, input int stop_at, output logic [9:0] got);
    got = '0;
    wait_rts(min_runs);
    tick(20);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      if (i == stop_at) return;
      dev_clk_low = 1'b0;
      if (i < 10) got[i] = ps2_data_in;
      if (i == 9) dev_data_low = ack;
      if (i == 10) begin
        dev_data_low = 1'b0;
        return;
      end
      tick(HALF);
    end
  endtask
  task automatic wait_result(input int bd, input int be, output bit d, output bit e);
    d = 1'b0;
    e = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      d = done || done_cnt > bd;
      e = err || err_cnt > be;
      if (d || e) break;
    end
  endtask
  initial begin
    logic [9:0] got;
    bit d, e;
    int r0, bd, be;
    tick(3);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {done, err}, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b0;
    tick(5);
    r0 = inh_runs;
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'hF4);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    check("busy_during_inhibit", busy, 1);
    dev_frame(r0 + 1, 1'b1, 99, got);
    check("frame_f4", got, 10'h2F4);
    wait_result(bd, be, d, e);
    check("f4_done", d, 1);
    check("f4_err", e, 0);
    #1 tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready", tx_ready, 1);
    @(negedge clk);
    check("b2b_busy", busy, 1);
    tx_valid = 1'b0;
    check("f4_done_once", done_cnt - bd, 1);
    dev_frame(r0 + 2, 1'b1, 99, got);
    check("frame_ff", got, 10'h3FF);
    wait_result(bd + 1, be, d, e);
    check("ff_done", d, 1);
    tick(100);
    check("no_queued_req", inh_runs - r0, 2);
    check("two_dones", done_cnt - bd, 2);
    check("no_err", err_cnt - be, 0);
`ifdef PS2_TX_RETRY_EN
    r0 = inh_runs;
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'hF4);
    for (int k = 1; k <= 3; k++) begin
      dev_frame(r0 + k, k == 3, 99, got);
      check("retry_frame", got, model_frame(8'hF4));
    end
    wait_result(bd, be, d, e);
    check("retry_done", d, 1);
    check("retry_err", e, 0);
    tick(50);
    check("retry_phases", inh_runs - r0, 3);
    check("retry_one_done", done_cnt - bd, 1);
    check("retry_no_err", err_cnt - be, 0);
`else
    r0 = inh_runs;
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'hF4);
    dev_frame(r0 + 1, 1'b0, 99, got);
    wait_result(bd, be, d, e);
    check("nack_err", e, 1);
    check("nack_done", d, 0);
    check("nack_ready", tx_ready, 1);
    check("nack_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    tick(20);
    r0 = inh_runs;
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'h3C);
    wait_rts(r0 + 1);
    wait_result(bd, be, d, e);
    tick(1);
    check("tmo_err", e, 1);
    check("tmo_done", d, 0);
    check("tmo_latency", err_cyc - send_cyc, TMO);
    check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("tmo_ready", tx_ready, 1);
`endif
    tick(20);
    r0 = inh_runs;
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'h2A);
    dev_frame(r0 + 1, 1'b1, 4, got);
    check("pre_rst_bits", got[3:0], 4'hA);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_busy", busy, 0);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(10);
    r0 = inh_runs;
    send_byte(8'hA5);
    dev_frame(r0 + 1, 1'b1, 99, got);
    check("frame_a5", got, model_frame(8'hA5));
    wait_result(bd, be, d, e);
    check("a5_done", d, 1);
    check("a5_err", e, 0);
    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
